// File: rtl/sp_writeback_arbiter.sv
// SPR write-back arbiter: one holding slot per unit, round-robin onto the single sp_reg_file write port.
// Optional SP_WB_BYPASS_EN: when no slot is held, incoming legal results arbitrate directly (zero latency).
module sp_writeback_arbiter #(
    parameter int unsigned UNITS       = 3,
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [UNITS-1:0]                      unit_valid,
    output logic [UNITS-1:0]                      unit_ready,
    input  logic [UNITS-1:0][9:0]                 unit_addr,
    input  logic [UNITS-1:0][31:0]                unit_value,
    input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]     unit_rs_id,
    output logic [9:0]                            write_addr,
    output logic                                  write_enable,
    output logic [31:0]                           write_value,
    output logic [RS_ID_WIDTH-1:0]                write_rs_id,
    output logic                                  illegal_spr,
    output logic [9:0]                            illegal_spr_addr
);

    localparam int unsigned PTR_W = (UNITS > 1) ? $clog2(UNITS) : 1;

    localparam logic [9:0] SPR_XER = 10'd1;
    localparam logic [9:0] SPR_LR  = 10'd8;
    localparam logic [9:0] SPR_CTR = 10'd9;

    logic [UNITS-1:0]                  held_valid;
    logic [UNITS-1:0][9:0]             held_addr;
    logic [UNITS-1:0][31:0]            held_value;
    logic [UNITS-1:0][RS_ID_WIDTH-1:0] held_rs_id;
    logic [PTR_W-1:0]                  rr_ptr;

    logic [UNITS-1:0] legal;
    logic [UNITS-1:0] accept;
    logic [UNITS-1:0] req;
    logic [UNITS-1:0] grant;
    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic             bypass_sel;
    logic             ill_hit;
    logic [9:0]       ill_addr;

    always_comb begin
        for (int unsigned i = 0; i < UNITS; i++) begin
            legal[i] = (unit_addr[i] == SPR_XER) || (unit_addr[i] == SPR_LR) ||
                       (unit_addr[i] == SPR_CTR);
        end
    end

`ifdef SP_WB_BYPASS_EN
    // With nothing held, live legal inputs compete under the same round-robin rule.
    assign bypass_sel = ~|held_valid;
    assign req        = bypass_sel ? (unit_valid & legal) : held_valid;
`else
    assign bypass_sel = 1'b0;
    assign req        = held_valid;
`endif

    always_comb begin
        int unsigned cand;
        cand      = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < UNITS; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= UNITS) begin
                cand = cand - UNITS;
            end
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Masking grant with held_valid keeps ready independent of unit_valid in bypass mode.
    assign unit_ready = ~held_valid | (grant & held_valid);
    assign accept     = unit_valid & unit_ready;

    always_comb begin
        write_enable = grant_any;
        write_addr   = '0;
        write_value  = '0;
        write_rs_id  = '0;
        if (grant_any) begin
            if (bypass_sel) begin
                write_addr  = unit_addr[grant_idx];
                write_value = unit_value[grant_idx];
                write_rs_id = unit_rs_id[grant_idx];
            end else begin
                write_addr  = held_addr[grant_idx];
                write_value = held_value[grant_idx];
                write_rs_id = held_rs_id[grant_idx];
            end
        end
    end

    always_comb begin
        ill_hit  = 1'b0;
        ill_addr = '0;
        for (int unsigned i = 0; i < UNITS; i++) begin
            if (!ill_hit && accept[i] && !legal[i]) begin
                ill_hit  = 1'b1;
                ill_addr = unit_addr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_valid       <= '0;
            held_addr        <= '0;
            held_value       <= '0;
            held_rs_id       <= '0;
            rr_ptr           <= '0;
            illegal_spr      <= 1'b0;
            illegal_spr_addr <= '0;
        end else begin
            for (int unsigned i = 0; i < UNITS; i++) begin
                // A refill on the granted slot wins over the clear; an illegal refill leaves it empty.
                if (accept[i] && legal[i] && !(bypass_sel && grant[i])) begin
                    held_valid[i] <= 1'b1;
                    held_addr[i]  <= unit_addr[i];
                    held_value[i] <= unit_value[i];
                    held_rs_id[i] <= unit_rs_id[i];
                end else if (grant[i]) begin
                    held_valid[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                if (grant_idx == PTR_W'(UNITS - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
            illegal_spr <= ill_hit;
            if (ill_hit) begin
                illegal_spr_addr <= ill_addr;
            end
        end
    end

endmodule

// File: tb/tb_sp_writeback_arbiter.sv
// Self-checking bench for sp_writeback_arbiter (default build): scoreboard of expected writes plus per-scenario checks.
module tb_sp_writeback_arbiter;

    localparam int unsigned UNITS = 3;
    localparam int unsigned RSW   = 5;

    typedef struct {
        logic [9:0]     addr;
        logic [31:0]    value;
        logic [RSW-1:0] rs;
    } wr_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [UNITS-1:0]            unit_valid = '0;
    logic [UNITS-1:0]            unit_ready;
    logic [UNITS-1:0][9:0]       unit_addr  = '0;
    logic [UNITS-1:0][31:0]      unit_value = '0;
    logic [UNITS-1:0][RSW-1:0]   unit_rs_id = '0;
    logic [9:0]                  write_addr;
    logic                        write_enable;
    logic [31:0]                 write_value;
    logic [RSW-1:0]              write_rs_id;
    logic                        illegal_spr;
    logic [9:0]                  illegal_spr_addr;

    int  errors = 0;
    int  checks = 0;
    wr_t sb[$];

    sp_writeback_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RSW)) dut (
        .clk              (clk),
        .rst              (rst),
        .unit_valid       (unit_valid),
        .unit_ready       (unit_ready),
        .unit_addr        (unit_addr),
        .unit_value       (unit_value),
        .unit_rs_id       (unit_rs_id),
        .write_addr       (write_addr),
        .write_enable     (write_enable),
        .write_value      (write_value),
        .write_rs_id      (write_rs_id),
        .illegal_spr      (illegal_spr),
        .illegal_spr_addr (illegal_spr_addr)
    );

    always #5 clk = ~clk;

    // Every write seen on the port must be the next expected one.
    always @(negedge clk) begin
        if (rst && write_enable) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d value=%h rs=%0d, required no write",
                         write_addr, write_value, write_rs_id);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (write_addr !== e.addr || write_value !== e.value || write_rs_id !== e.rs) begin
                    errors++;
                    $display("FAIL write_data: got addr=%0d value=%h rs=%0d, required addr=%0d value=%h rs=%0d",
                             write_addr, write_value, write_rs_id, e.addr, e.value, e.rs);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic set_unit(input int u, input logic [9:0] a, input logic [31:0] v,
                            input logic [RSW-1:0] r, input bit push);
        wr_t e;
        unit_valid[u] = 1'b1;
        unit_addr[u]  = a;
        unit_value[u] = v;
        unit_rs_id[u] = r;
        if (push) begin
            e.addr  = a;
            e.value = v;
            e.rs    = r;
            sb.push_back(e);
        end
    endtask

    task automatic do_reset;
        rst        = 1'b0;
        unit_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b0 || write_addr !== 10'd0 || write_value !== 32'd0 || write_rs_id !== 5'd0) begin
            errors++;
            $display("FAIL reset_write_port: got we=%b addr=%0d value=%h rs=%0d, required all 0",
                     write_enable, write_addr, write_value, write_rs_id);
        end
        checks++;
        if (unit_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 111", unit_ready);
        end
        checks++;
        if (illegal_spr !== 1'b0 || illegal_spr_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_illegal: got %b/%0d, required 0/0", illegal_spr, illegal_spr_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Fill all three slots; only unit0 gets written before reset hits mid-cycle.
        @(posedge clk);
        #1;
        set_unit(0, 10'd1, 32'h0000_00A0, 5'd1, 1'b1);
        set_unit(1, 10'd8, 32'h0000_00A1, 5'd2, 1'b0);
        set_unit(2, 10'd9, 32'h0000_00A2, 5'd3, 1'b0);
        @(posedge clk);
        #1;
        unit_valid = '0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_midtraffic_we: got %b, required 0", write_enable);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (write_enable !== 1'b0 || unit_ready !== 3'b111) begin
                errors++;
                $display("FAIL reset_after_release: cycle %0d got we=%b ready=%b, required we=0 ready=111",
                         c, write_enable, unit_ready);
            end
        end
    endtask

    task automatic test_single;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        set_unit(0, 10'd8, 32'hDEAD_BEEF, 5'd3, 1'b1);
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got we=%b in accept cycle, required 0", write_enable);
        end
        @(posedge clk);
        #1;
        unit_valid = '0;
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b1 || write_addr !== 10'd8 || write_value !== 32'hDEAD_BEEF || write_rs_id !== 5'd3) begin
            errors++;
            $display("FAIL single_write: got we=%b addr=%0d value=%h rs=%0d, required 1/8/deadbeef/3",
                     write_enable, write_addr, write_value, write_rs_id);
        end
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: got we=%b, required 0", write_enable);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_contention;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        set_unit(0, 10'd1, 32'h1000_0000, 5'd0, 1'b1);
        set_unit(1, 10'd8, 32'h1000_0001, 5'd1, 1'b1);
        set_unit(2, 10'd9, 32'h1000_0002, 5'd2, 1'b1);
        @(posedge clk);
        #1;
        unit_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (write_enable !== 1'b1) begin
                errors++;
                $display("FAIL contention_consecutive: cycle %0d got we=%b, required 1", c, write_enable);
            end
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL contention_drain: got %0d pending, required 0", sb.size());
        end
        // Pointer has wrapped to 0, so unit0 goes before unit2.
        @(posedge clk);
        #1;
        set_unit(0, 10'd8, 32'h2000_0000, 5'd5, 1'b1);
        set_unit(2, 10'd1, 32'h2000_0002, 5'd6, 1'b1);
        @(posedge clk);
        #1;
        unit_valid = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL contention_second_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        bit rdy;
        int n;
        bit exp_rdy[6];
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        n = 0;
        do_reset();
        @(posedge clk);
        #1;
        set_unit(0, 10'd1, 32'h0000_000A, 5'd20, 1'b1);
        set_unit(1, 10'd8, 32'h0000_0100, 5'd10, 1'b1);
        set_unit(2, 10'd9, 32'h0000_000C, 5'd22, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rdy = unit_ready[1];
            checks++;
            if (rdy !== exp_rdy[c]) begin
                errors++;
                $display("FAIL backpressure_ready1: cycle %0d got %b, required %b", c, rdy, exp_rdy[c]);
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                unit_valid[0] = 1'b0;
                unit_valid[2] = 1'b0;
            end
            if (rdy) begin
                n++;
                if (n < 4) begin
                    set_unit(1, 10'd8, 32'h0000_0100 + 32'(n), 5'(10 + n), 1'b1);
                end else begin
                    unit_valid[1] = 1'b0;
                end
            end
        end
        unit_valid = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_illegal;
        do_reset();
        @(posedge clk);
        #1;
        set_unit(2, 10'd5, 32'h0000_0077, 5'd7, 1'b0);
        @(negedge clk);
        checks++;
        if (illegal_spr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_early: got %b, required 0", illegal_spr);
        end
        @(posedge clk);
        #1;
        unit_valid = '0;
        @(negedge clk);
        checks++;
        if (illegal_spr !== 1'b1 || illegal_spr_addr !== 10'd5) begin
            errors++;
            $display("FAIL illegal_pulse: got %b/%0d, required 1/5", illegal_spr, illegal_spr_addr);
        end
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL illegal_no_write: got we=%b, required 0", write_enable);
        end
        @(posedge clk);
        #1;
        set_unit(0, 10'd3, 32'h0000_0033, 5'd8, 1'b0);
        set_unit(1, 10'd7, 32'h0000_0077, 5'd9, 1'b0);
        @(negedge clk);
        checks++;
        if (illegal_spr !== 1'b0 || illegal_spr_addr !== 10'd5) begin
            errors++;
            $display("FAIL illegal_pulse_end: got %b/%0d, required 0/5", illegal_spr, illegal_spr_addr);
        end
        @(posedge clk);
        #1;
        unit_valid = '0;
        @(negedge clk);
        checks++;
        if (illegal_spr !== 1'b1 || illegal_spr_addr !== 10'd3) begin
            errors++;
            $display("FAIL illegal_lowest: got %b/%0d, required 1/3", illegal_spr, illegal_spr_addr);
        end
        @(negedge clk);
        checks++;
        if (illegal_spr !== 1'b0) begin
            errors++;
            $display("FAIL illegal_second_end: got %b, required 0", illegal_spr);
        end
    endtask

    task automatic test_refill;
        bit ok;
        do_reset();
        @(posedge clk);
        #1;
        set_unit(0, 10'd9, 32'hA5A5_0000, 5'd1, 1'b1);
        @(posedge clk);
        #1;
        set_unit(1, 10'd1, 32'h0000_0055, 5'd4, 1'b1);
        set_unit(0, 10'd8, 32'h0000_0001, 5'd2, 1'b1);
        @(negedge clk);
        checks++;
        if (unit_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL refill_ready0: got %b, required 1", unit_ready[0]);
        end
        @(posedge clk);
        #1;
        unit_valid = '0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL refill_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_refill();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
